// File: rtl/pll_seq_pkg.sv
// Shared state encodings and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 2;

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_HOLD      = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_FAULT     = 3'd5;

  // Counter width wide enough to reach (largest cycle count - 1).
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock-qualification sequencer running on the PLL reference clock.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned PLL_RST_CYCLES      = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 7425000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned HOLD_CYCLES         = 256,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       soft_reset_i,
  input  logic       pll_locked_i,
  output logic       pll_rst_o,
  output logic       core_reset_n_o,
  output logic       ready_o,
  output logic       lock_lost_o,
  output logic       fault_o,
  output logic [1:0] retry_cnt_o
);

  localparam int unsigned CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                            LOCK_STABLE_CYCLES, HOLD_CYCLES);

  logic               locked_s;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic [RETRY_W-1:0] retry_d, retry_inc;
  logic               lock_lost_d;
  logic               timeout;
  logic               tmo_now, tmo_next;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_locked (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked_i),
    .q     (locked_s)
  );

  // Next-state, counter and retry bookkeeping.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_cnt_o;
    lock_lost_d = 1'b0;
    tmo_now     = (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE);
    timeout     = tmo_now && (tmo_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1));
    retry_inc   = (retry_cnt_o == 2'd3) ? 2'd3 : retry_cnt_o + 2'd1;

    case (state_q)
      ST_PLL_RST: begin
        if (phase_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        // Timeout wins over any lock activity so chatter cannot stall forever.
        if (timeout) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_W'(MAX_RETRIES)) ? ST_FAULT : ST_PLL_RST;
        end else if (state_q == ST_WAIT_LOCK) begin
          if (locked_s) state_d = ST_STABLE;
        end else if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (phase_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!locked_s) begin
          state_d     = ST_PLL_RST;
          lock_lost_d = 1'b1;
        end else if (phase_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d     = ST_PLL_RST;
          lock_lost_d = 1'b1;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_PLL_RST;
      end
    endcase

    if (soft_reset_i) begin
      state_d     = ST_PLL_RST;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end

    tmo_next = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE);

    // Phase counter restarts on every state change and is held at zero during soft reset.
    if (soft_reset_i || (state_d != state_q))
      phase_d = '0;
    else if ((state_q == ST_PLL_RST) || (state_q == ST_STABLE) || (state_q == ST_HOLD))
      phase_d = phase_q + CNT_W'(1);
    else
      phase_d = phase_q;

    // Timeout spans WAIT_LOCK and STABLE together; it only restarts after a PLL reset.
    if (!soft_reset_i && tmo_now && tmo_next)
      tmo_d = tmo_q + CNT_W'(1);
    else
      tmo_d = '0;
  end

  // State, counters and outputs decoded from the next state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_PLL_RST;
      phase_q        <= '0;
      tmo_q          <= '0;
      pll_rst_o      <= 1'b1;
      core_reset_n_o <= 1'b0;
      ready_o        <= 1'b0;
      lock_lost_o    <= 1'b0;
      fault_o        <= 1'b0;
      retry_cnt_o    <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      tmo_q          <= tmo_d;
      pll_rst_o      <= (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
      core_reset_n_o <= (state_d == ST_RUN);
      ready_o        <= (state_d == ST_RUN);
      lock_lost_o    <= lock_lost_d;
      fault_o        <= (state_d == ST_FAULT);
      retry_cnt_o    <= retry_d;
    end
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sits directly around the fractional video/system PLL.
- Drives the PLL's active-high reset input and consumes its asynchronous locked output.
- Debounces lock and retries the PLL on lock timeout. Releases the core reset only after lock has been stable plus a hold-off.
- Re-sequences on loss of lock. Runs entirely on the PLL reference clock, so it never depends on PLL outputs.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for pll_locked_i (minimum 2).
- PLL_RST_CYCLES, 64: cycles pll_rst_o is held high per attempt (minimum 1).
- LOCK_TIMEOUT_CYCLES, 7425000: cycles (100 ms at 74.25 MHz) allowed from end of PLL reset to stable lock.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required (minimum 1).
- HOLD_CYCLES, 256: extra cycles the core reset stays asserted after stable lock (minimum 1).
- MAX_RETRIES, 3: timeouts tolerated before fault (minimum 1).

Ports:
- refclk, input, 1: sole clock (74.25 MHz reference).
- rst_n, input, 1: asynchronous active-low reset.
- soft_reset_i, input, 1: synchronous level request to restart the sequence.
- pll_locked_i, input, 1: PLL locked, asynchronous to refclk.
- pll_rst_o, output, 1: active-high PLL reset.
- core_reset_n_o, output, 1: active-low core reset, deasserted synchronously to refclk.
- ready_o, output, 1: high while in RUN.
- lock_lost_o, output, 1: one-cycle pulse on loss of lock while in HOLD or RUN.
- fault_o, output, 1: high in FAULT.
- retry_cnt_o, output, 2: timeouts counted since last RUN, saturating at 3.

Behaviour:
- Clock and reset: one clock, refclk. Reset rst_n is asynchronous and active-low.
- Reset values: state PLL_RST, pll_rst_o=1, core_reset_n_o=0, ready_o=0, lock_lost_o=0, fault_o=0, retry_cnt_o=0. All counters 0 and synchronizer flops 0.
- Registered outputs: every output is registered and decoded from the next state, so it changes on the same edge as the state.
- locked_s: pll_locked_i after SYNC_STAGES flops. Only locked_s is used internally.
- Counters:
  - phase_cnt: per-state cycle counter, cleared on every state change.
  - tmo_cnt: runs in WAIT_LOCK and STABLE; cleared on entering WAIT_LOCK from PLL_RST.
- PLL_RST: pll_rst_o=1, core_reset_n_o=0. Exit to WAIT_LOCK when phase_cnt==PLL_RST_CYCLES-1.
- WAIT_LOCK: pll_rst_o=0.
  - locked_s=1 -> STABLE.
  - tmo_cnt==LOCK_TIMEOUT_CYCLES-1 -> increment retry count. If the new count equals MAX_RETRIES -> FAULT, else -> PLL_RST.
- STABLE:
  - locked_s=0 -> WAIT_LOCK; tmo_cnt is NOT cleared, so lock chatter cannot evade the timeout.
  - locked_s=1 and phase_cnt==LOCK_STABLE_CYCLES-1 -> HOLD.
  - Timeout in STABLE is handled as in WAIT_LOCK.
  - Timeout and locked_s=0 in the same cycle: timeout wins.
- HOLD:
  - locked_s=0 -> pulse lock_lost_o, go to PLL_RST.
  - phase_cnt==HOLD_CYCLES-1 -> RUN.
- RUN: core_reset_n_o=1, ready_o=1, retry count cleared on entry.
  - locked_s=0 -> PLL_RST. In the same edge core_reset_n_o=0, ready_o=0, lock_lost_o=1 for one cycle.
- FAULT: pll_rst_o=1, core_reset_n_o=0, fault_o=1. Left only by soft_reset_i or rst_n.
- soft_reset_i=1 in any state:
  - Next state PLL_RST, phase_cnt held at 0, retry count cleared, fault_o cleared.
  - The PLL_RST count starts the cycle after soft_reset_i falls.
  - soft_reset_i has priority over all other transitions.
- Latency: with lock already solid, from the first refclk edge sampling pll_locked_i=1 while in WAIT_LOCK to core_reset_n_o=1 is SYNC_STAGES+1+LOCK_STABLE_CYCLES+HOLD_CYCLES edges.
- Reset mid-operation: rst_n low forces the reset values immediately (asynchronously), including pll_rst_o=1.
- Width rules:
  - Counters are sized by $clog2 of the largest cycle parameter.
  - retry count is 2 bits, saturating.
  - MAX_RETRIES is limited to 3.

Decomposition:
- Package pll_seq_pkg:
  - state enum: PLL_RST, WAIT_LOCK, STABLE, HOLD, RUN, FAULT.
  - function for counter width.
- Sub-module sync_bit: parameterized SYNC_STAGES flop chain with async active-low reset to 0, used for pll_locked_i.
- Everything else is one FSM plus counters in pll_lock_sequencer.

Test Plan (all scenarios use SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=50, LOCK_STABLE_CYCLES=8, HOLD_CYCLES=4, MAX_RETRIES=3):
1. Nominal start. Release rst_n; raise pll_locked_i 10 cycles after pll_rst_o falls and hold it -> pll_rst_o high exactly 4 cycles; core_reset_n_o and ready_o rise 15 edges after the first edge that samples locked=1; retry_cnt_o=0.
2. Chatter. Lock high 5 cycles, low 1, then high -> STABLE restarts; release occurs 15 edges after the final rise; no lock_lost_o pulse.
3. Timeout and fault. pll_locked_i held 0 -> three PLL_RST bursts (4 cycles each); retry_cnt_o steps 1, 2, then fault_o=1 with pll_rst_o=1 steady; soft_reset_i pulse -> fault_o=0, retry_cnt_o=0, new 4-cycle PLL_RST.
4. Loss of lock in RUN. Drop pll_locked_i after ready_o=1 -> 3 edges later lock_lost_o is a 1-cycle pulse, core_reset_n_o=0, ready_o=0, pll_rst_o=1; re-lock -> normal 15-edge release.
5. Async reset in HOLD. Assert rst_n low mid-HOLD between clock edges -> outputs take reset values immediately, without a refclk edge.
6. Simultaneous events. soft_reset_i=1 in the same cycle as the HOLD->RUN transition -> state PLL_RST, core_reset_n_o stays 0, ready_o never pulses.
